memory_arbiter: RTL and testbench
=================================

// Module: memory_arbiter
// PURPOSE
//  Shares one unified single-ported memory bus between the datapath's instruction-fetch port
//  (imem_*) and data port (dmem_*). Sits between datapath and the memory/RAM model.
//  Issues one transaction at a time and returns a one-cycle ihit/dhit pulse with the load data.
//  Data requests have priority over fetch.
// PARAMETERS
//  ADDR_W   32  address width of all ports
//  DATA_W   32  data width of all ports
// PORTS
//  clk         in   1       system clock
//  nrst        in   1       asynchronous active-low reset
//  imem_ren    in   1       fetch request (level)
//  imem_addr   in   ADDR_W  fetch address
//  imem_load   out  DATA_W  fetched word, valid when ihit
//  ihit        out  1       fetch complete (1-cycle pulse)
//  dmem_ren    in   1       load request (level)
//  dmem_wen    in   1       store request (level); ren & wen both high is treated as a store
//  dmem_addr   in   ADDR_W  load/store address
//  dmem_store  in   DATA_W  store data
//  dmem_width  in   3       access width, funct3 encoding ([1:0]: 00=B, 01=H, 10=W)
//  dmem_load   out  DATA_W  raw load word (the datapath extends it), valid when dhit
//  dhit        out  1       data access complete (1-cycle pulse)
//  mem_req     out  1       bus request, held until mem_ready
//  mem_we      out  1       1 = write
//  mem_addr    out  ADDR_W  bus address
//  mem_wdata   out  DATA_W  bus write data
//  mem_width   out  3       bus access width (fetch is always 3'b010)
//  mem_rdata   in   DATA_W  bus read data, valid with mem_ready
//  mem_ready   in   1       bus completes the current request this cycle
// BEHAVIOUR
//  - Reset: state=IDLE; mem_req, mem_we, ihit, dhit = 0; all data/address outputs = '0.
//  - States IDLE, IBUS, DBUS, plus a registered hit flag.
//  - IDLE: if dmem_ren|dmem_wen, go to DBUS. Otherwise, if imem_ren, go to IBUS.
//    Addr, wdata, we and width are latched on that edge.
//  - IBUS/DBUS: mem_req=1. Bus outputs come from the latched registers and stay stable until
//    mem_ready. Requester inputs are ignored while a transaction is in flight, even if they drop.
//  - On mem_ready in xBUS: capture mem_rdata into imem_load/dmem_load (stores leave dmem_load
//    unchanged), pulse ihit or dhit for exactly the next cycle, and return to IDLE.
//  - Latency: request seen at cycle 0, mem_req from cycle 1. mem_ready at cycle k gives the hit
//    at cycle k+1. A zero-wait bus gives a 2-cycle request-to-hit latency.
//  - Re-issue guard: in the cycle a port's hit is high, that same port's request is not accepted.
//    This covers the requester's one-cycle deassert lag. The other port may be granted in that cycle.
//  - Simultaneous imem and dmem requests in IDLE: grant data. The fetch stays pending and is
//    granted next, or in the dhit cycle via the guard rule.
//  - mem_ready while IDLE: ignored.
//  - mem_ready never arrives: the arbiter waits indefinitely (no timeout).
//  - Reset mid-transaction: mem_req drops immediately (async), the transaction is abandoned,
//    and no hit is produced.
// CONFIGURATION
//  - MEMORY_ARBITER_PERF_EN defined: adds outputs perf_ifetch_cnt, perf_daccess_cnt and
//    perf_wait_cnt (32b each, reset 0, wrap at 2^32).
//      - perf_ifetch_cnt and perf_daccess_cnt increment on each ihit and dhit respectively.
//      - perf_wait_cnt increments every cycle with mem_req=1 and mem_ready=0.
//  - Not defined: these ports and their logic do not exist. Functional behaviour is identical.
// STRUCTURE
//  - rv32ima_pkg: add arb_state_t enum {ARB_IDLE, ARB_IBUS, ARB_DBUS} and the constant
//    ARB_FETCH_WIDTH = 3'b010. Ports use word_t for the 32b fields.
//  - Optional sub-module memory_arbiter_perf (the three counters), instantiated only under
//    MEMORY_ARBITER_PERF_EN.
//  - A memory_arbiter_if interface with dp/mem modports mirrors the other *_if files.
// TESTING
//  1. Reset, then imem_ren=1 with addr 0x0000_0000 on a zero-wait bus returning 0x0000_0013
//     -> mem_req at cycle 1 with mem_we=0 and mem_width=010; ihit at cycle 2 with imem_load=0x13.
//  2. Same-cycle imem_ren (0x4) and dmem_ren (0x100); bus returns 0xDEAD_BEEF then 0x13
//     -> data is served first and dhit carries 0xDEADBEEF; the fetch of 0x4 starts in the
//     dhit cycle; ihit follows.
//  3. Store with dmem_wen, addr 0x200, data 0x1234_5678, width 001, and mem_ready delayed
//     3 cycles -> mem_* stay stable for 4 cycles with mem_we=1; single dhit; dmem_load unchanged.
//  4. dmem_ren held one extra cycle after dhit -> no second bus transaction is issued.
//  5. Assert nrst low while in DBUS waiting -> mem_req=0 immediately; no dhit after release;
//     state is IDLE.
//  6. With MEMORY_ARBITER_PERF_EN, run test 3 -> perf_daccess_cnt=1, perf_wait_cnt=3.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types for the unified memory-bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Provides: ADDR_W/DATA_W, word_t/addr_t, the arbiter FSM state enum,
// the fixed fetch access width and the latched bus-command struct.
package memory_arbiter_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_IBUS = 2'd1,
      ARB_DBUS = 2'd2
   } arb_state_t;

   // Instruction fetches are always full-word accesses (funct3 LW encoding).
   localparam logic [2:0] ARB_FETCH_WIDTH = 3'b010;

   // Everything the bus sees for one transaction, captured on the grant edge.
   typedef struct packed {
      addr_t      addr;
      word_t      wdata;
      logic       we;
      logic [2:0] width;
   } bus_cmd_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the datapath-side fetch/data ports and the memory-side bus.
// Latency: n/a (wires only).
// Backpressure: mem_req is held until mem_ready; requesters hold their level until their hit.
//
// Modports:
//   arb - the arbiter itself (consumes requests and bus responses)
//   dp  - the datapath (drives imem_*/dmem_* requests, receives loads and hits)
//   mem - the memory/RAM model (receives mem_* requests, drives mem_rdata/mem_ready)
interface memory_arbiter_if;
   import memory_arbiter_pkg::*;

   // instruction-fetch port
   logic       imem_ren;
   addr_t      imem_addr;
   word_t      imem_load;
   logic       ihit;
   // data port
   logic       dmem_ren;
   logic       dmem_wen;
   addr_t      dmem_addr;
   word_t      dmem_store;
   logic [2:0] dmem_width;
   word_t      dmem_load;
   logic       dhit;
   // unified memory bus
   logic       mem_req;
   logic       mem_we;
   addr_t      mem_addr;
   word_t      mem_wdata;
   logic [2:0] mem_width;
   word_t      mem_rdata;
   logic       mem_ready;

   modport arb (
      input  imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
      input  mem_rdata, mem_ready,
      output imem_load, ihit, dmem_load, dhit,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_width
   );

   modport dp (
      output imem_ren, imem_addr, dmem_ren, dmem_wen, dmem_addr, dmem_store, dmem_width,
      input  imem_load, ihit, dmem_load, dhit
   );

   modport mem (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_width,
      output mem_rdata, mem_ready
   );

endinterface

// File: rtl/memory_arbiter_perf.sv
// Performance counters for the memory arbiter (fetches, data accesses, bus wait cycles).
// Latency: counts are visible the cycle after the event that bumps them.
// Backpressure: none; purely observes, never stalls.
//
// Ports: clk, nrst; ihit_i, dhit_i, mem_req_i, mem_ready_i (observed events);
//        ifetch_cnt_o, daccess_cnt_o, wait_cnt_o (32b, wrap at 2^32).
// Only compiled when MEMORY_ARBITER_PERF_EN is defined.
`ifdef MEMORY_ARBITER_PERF_EN
module memory_arbiter_perf
   import memory_arbiter_pkg::*;
(
   input  logic  clk,
   input  logic  nrst,
   input  logic  ihit_i,
   input  logic  dhit_i,
   input  logic  mem_req_i,
   input  logic  mem_ready_i,
   output word_t ifetch_cnt_o,
   output word_t daccess_cnt_o,
   output word_t wait_cnt_o
);

   word_t ifetch_q, daccess_q, wait_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ifetch_q  <= '0;
         daccess_q <= '0;
         wait_q    <= '0;
      end else begin
         if (ihit_i)                   ifetch_q  <= ifetch_q + 1'b1;
         if (dhit_i)                   daccess_q <= daccess_q + 1'b1;
         if (mem_req_i && !mem_ready_i) wait_q   <= wait_q + 1'b1;
      end
   end

   assign ifetch_cnt_o  = ifetch_q;
   assign daccess_cnt_o = daccess_q;
   assign wait_cnt_o    = wait_q;

endmodule
`endif

// File: rtl/memory_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data access; data wins.
// Latency: request at cycle 0 -> mem_req from cycle 1; mem_ready at cycle k -> hit at k+1.
// Backpressure: one transaction in flight; bus outputs held stable until mem_ready, no timeout.
//
// Ports: clk, nrst (async active-low); bus (memory_arbiter_if.arb) carrying imem_*, dmem_*, mem_*.
// Optional (MEMORY_ARBITER_PERF_EN): perf_ifetch_cnt, perf_daccess_cnt, perf_wait_cnt.
module memory_arbiter
   import memory_arbiter_pkg::*;
(
   input  logic          clk,
   input  logic          nrst,
   memory_arbiter_if.arb bus
`ifdef MEMORY_ARBITER_PERF_EN
   ,
   output word_t         perf_ifetch_cnt,
   output word_t         perf_daccess_cnt,
   output word_t         perf_wait_cnt
`endif
);

   arb_state_t state_q, state_d;
   bus_cmd_t   cmd_q, cmd_d;
   logic       ihit_q, ihit_d;
   logic       dhit_q, dhit_d;
   word_t      iload_q, iload_d;
   word_t      dload_q, dload_d;

   logic       d_go, i_go;
   logic       mem_req_s;

   // A port whose hit is showing this cycle is still holding its request
   // (the requester only reacts to the hit one cycle late), so it is masked.
   assign d_go = (bus.dmem_ren | bus.dmem_wen) & ~dhit_q;
   assign i_go = bus.imem_ren & ~ihit_q;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) state_q <= ARB_IDLE;
      else       state_q <= state_d;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (d_go)      state_d = ARB_DBUS;
            else if (i_go) state_d = ARB_IBUS;
         end
         ARB_IBUS, ARB_DBUS: begin
            if (bus.mem_ready) state_d = ARB_IDLE;
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // mem_req decodes straight from the state register so an async reset
   // drops it at once and abandons any transaction in flight.
   always_comb begin
      mem_req_s     = (state_q != ARB_IDLE);
      bus.mem_req   = mem_req_s;
      bus.mem_we    = cmd_q.we & mem_req_s;
      bus.mem_addr  = cmd_q.addr;
      bus.mem_wdata = cmd_q.wdata;
      bus.mem_width = cmd_q.width;
      bus.ihit      = ihit_q;
      bus.dhit      = dhit_q;
      bus.imem_load = iload_q;
      bus.dmem_load = dload_q;
   end

   // ---------------------------------------------------------------- command / response path
   always_comb begin
      cmd_d   = cmd_q;
      ihit_d  = 1'b0;
      dhit_d  = 1'b0;
      iload_d = iload_q;
      dload_d = dload_q;

      // ren & wen together is a store: dmem_wen alone drives the write flag.
      if (state_q == ARB_IDLE) begin
         if (d_go) begin
            cmd_d.addr  = bus.dmem_addr;
            cmd_d.wdata = bus.dmem_store;
            cmd_d.we    = bus.dmem_wen;
            cmd_d.width = bus.dmem_width;
         end else if (i_go) begin
            cmd_d.addr  = bus.imem_addr;
            cmd_d.wdata = '0;
            cmd_d.we    = 1'b0;
            cmd_d.width = ARB_FETCH_WIDTH;
         end
      end

      if (bus.mem_ready) begin
         if (state_q == ARB_IBUS) begin
            ihit_d  = 1'b1;
            iload_d = bus.mem_rdata;
         end
         if (state_q == ARB_DBUS) begin
            dhit_d = 1'b1;
            if (!cmd_q.we) dload_d = bus.mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         cmd_q   <= '0;
         ihit_q  <= 1'b0;
         dhit_q  <= 1'b0;
         iload_q <= '0;
         dload_q <= '0;
      end else begin
         cmd_q   <= cmd_d;
         ihit_q  <= ihit_d;
         dhit_q  <= dhit_d;
         iload_q <= iload_d;
         dload_q <= dload_d;
      end
   end

`ifdef MEMORY_ARBITER_PERF_EN
   memory_arbiter_perf u_perf (
      .clk           (clk),
      .nrst          (nrst),
      .ihit_i        (ihit_q),
      .dhit_i        (dhit_q),
      .mem_req_i     (mem_req_s),
      .mem_ready_i   (bus.mem_ready),
      .ifetch_cnt_o  (perf_ifetch_cnt),
      .daccess_cnt_o (perf_daccess_cnt),
      .wait_cnt_o    (perf_wait_cnt)
   );
`endif

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios, then random requesters vs a transaction-level model.
// Latency: checks are cycle-exact (outputs sampled on the falling edge).
// Backpressure: the bench memory inserts random wait states and stray idle mem_ready pulses.
module tb_memory_arbiter;
   import memory_arbiter_pkg::*;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   memory_arbiter_if bus();

`ifdef MEMORY_ARBITER_PERF_EN
   word_t pf_i, pf_d, pf_w;
`endif

   memory_arbiter dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
`ifdef MEMORY_ARBITER_PERF_EN
      ,
      .perf_ifetch_cnt  (pf_i),
      .perf_daccess_cnt (pf_d),
      .perf_wait_cnt    (pf_w)
`endif
   );

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_idle();
      bus.imem_ren   = 1'b0;
      bus.imem_addr  = '0;
      bus.dmem_ren   = 1'b0;
      bus.dmem_wen   = 1'b0;
      bus.dmem_addr  = '0;
      bus.dmem_store = '0;
      bus.dmem_width = 3'b010;
      bus.mem_rdata  = '0;
      bus.mem_ready  = 1'b0;
   endtask

   function automatic addr_t rand_addr();
      logic [7:0] idx;
      idx = 8'($urandom);
      return {22'b0, idx, 2'b00};
   endfunction

   // ---------------- reference model state (transaction level)
   word_t      ref_mem [256];
   bit         m_busy, m_isd, m_we, m_ihit, m_dhit, nih, ndh;
   addr_t      m_addr;
   word_t      m_wdata, m_iload, m_dload;
   logic [2:0] m_width;
   int         w_left;
   int         cnt_i, cnt_d, cnt_w;
   // requester agents
   bit         i_req, i_drop, d_req, d_drop, d_ren, d_wen;
   addr_t      i_addr, d_addr;
   word_t      d_store;
   logic [2:0] d_width;
   bit         i_gr, d_gr;
   int         kind;
`ifdef MEMORY_ARBITER_PERF_EN
   word_t      snap_d, snap_w;
`endif

   initial begin
      nrst = 1'b0;
      drive_idle();
      repeat (2) @(negedge clk);
      // ---------------- reset state
      check("rst_req",   bus.mem_req,   0);
      check("rst_we",    bus.mem_we,    0);
      check("rst_ihit",  bus.ihit,      0);
      check("rst_dhit",  bus.dhit,      0);
      check("rst_addr",  bus.mem_addr,  0);
      check("rst_iload", bus.imem_load, 0);
      check("rst_dload", bus.dmem_load, 0);
      nrst = 1'b1;
      @(negedge clk);

      // ---------------- 1: single fetch, zero-wait bus
      bus.imem_ren = 1'b1; bus.imem_addr = 32'h0;
      @(negedge clk);
      check("t1_req",   bus.mem_req,   1);
      check("t1_we",    bus.mem_we,    0);
      check("t1_width", bus.mem_width, 3'b010);
      check("t1_addr",  bus.mem_addr,  32'h0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13;
      @(negedge clk);
      check("t1_ihit",  bus.ihit,      1);
      check("t1_iload", bus.imem_load, 32'h13);
      check("t1_idle",  bus.mem_req,   0);
      bus.imem_ren = 1'b0; bus.mem_ready = 1'b0;
      @(negedge clk);
      check("t1_ihit_off", bus.ihit, 0);

      // ---------------- 2: simultaneous fetch and load, data first
      bus.imem_ren = 1'b1; bus.imem_addr = 32'h4;
      bus.dmem_ren = 1'b1; bus.dmem_addr = 32'h100; bus.dmem_width = 3'b010;
      @(negedge clk);
      check("t2_dreq",  bus.mem_req,  1);
      check("t2_daddr", bus.mem_addr, 32'h100);
      check("t2_dwe",   bus.mem_we,   0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("t2_dhit",  bus.dhit,      1);
      check("t2_dload", bus.dmem_load, 32'hDEAD_BEEF);
      check("t2_ihit0", bus.ihit,      0);
      bus.dmem_ren = 1'b0; bus.mem_ready = 1'b0;
      @(negedge clk);
      check("t2_ireq",   bus.mem_req,   1);
      check("t2_iaddr",  bus.mem_addr,  32'h4);
      check("t2_iwidth", bus.mem_width, 3'b010);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h13;
      @(negedge clk);
      check("t2_ihit",  bus.ihit,      1);
      check("t2_iload", bus.imem_load, 32'h13);
      bus.imem_ren = 1'b0; bus.mem_ready = 1'b0;
      @(negedge clk);

      // ---------------- 3: halfword store with three wait states
`ifdef MEMORY_ARBITER_PERF_EN
      snap_d = pf_d; snap_w = pf_w;
`endif
      bus.dmem_wen = 1'b1; bus.dmem_addr = 32'h200;
      bus.dmem_store = 32'h1234_5678; bus.dmem_width = 3'b001;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t3_req",   bus.mem_req,   1);
         check("t3_we",    bus.mem_we,    1);
         check("t3_addr",  bus.mem_addr,  32'h200);
         check("t3_wdata", bus.mem_wdata, 32'h1234_5678);
         check("t3_width", bus.mem_width, 3'b001);
         check("t3_nohit", bus.dhit,      0);
         // requester changes its mind mid-flight; the bus must not notice
         if (i == 1) begin bus.dmem_wen = 1'b0; bus.dmem_addr = 32'h3FC; end
         if (i == 3) begin bus.mem_ready = 1'b1; bus.mem_rdata = 32'hBAD0_BAD0; end
      end
      @(negedge clk);
      check("t3_dhit",  bus.dhit,      1);
      check("t3_dload", bus.dmem_load, 32'hDEAD_BEEF);
      check("t3_idle",  bus.mem_req,   0);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check("t3_dhit_off", bus.dhit, 0);
`ifdef MEMORY_ARBITER_PERF_EN
      check("t6_daccess", pf_d - snap_d, 1);
      check("t6_wait",    pf_w - snap_w, 3);
`endif

      // ---------------- 4: load held one cycle past dhit -> no reissue
      bus.dmem_ren = 1'b1; bus.dmem_addr = 32'h100; bus.dmem_width = 3'b010;
      @(negedge clk);
      check("t4_req", bus.mem_req, 1);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFE_0001;
      @(negedge clk);
      check("t4_dhit",  bus.dhit,      1);
      check("t4_dload", bus.dmem_load, 32'hCAFE_0001);
      bus.mem_ready = 1'b0;           // dmem_ren deliberately still high
      @(negedge clk);
      check("t4_noreissue", bus.mem_req, 0);
      check("t4_dhit_off",  bus.dhit,    0);
      bus.dmem_ren = 1'b0;
      @(negedge clk);
      check("t4_idle", bus.mem_req, 0);

      // ---------------- 5: reset while waiting in DBUS
      bus.dmem_ren = 1'b1; bus.dmem_addr = 32'h300;
      @(negedge clk);
      check("t5_req", bus.mem_req, 1);
      #1 nrst = 1'b0;
      #1 check("t5_async_drop", bus.mem_req, 0);
      drive_idle();
      @(negedge clk);
      nrst = 1'b1;
      bus.mem_ready = 1'b1;           // stale completion must be ignored
      @(negedge clk);
      check("t5_nodhit", bus.dhit,    0);
      check("t5_noreq",  bus.mem_req, 0);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      check("t5_nodhit2", bus.dhit,         0);
      check("t5_state",   dut.state_q,      ARB_IDLE);

      // ---------------- random phase
      for (int k = 0; k < 256; k++) ref_mem[k] = $urandom;
      m_busy = 0; m_isd = 0; m_we = 0; m_ihit = 0; m_dhit = 0;
      m_addr = '0; m_wdata = '0; m_width = '0; m_iload = '0; m_dload = '0;
      w_left = 0; cnt_i = 0; cnt_d = 0; cnt_w = 0;
      i_req = 0; i_drop = 0; d_req = 0; d_drop = 0; d_ren = 0; d_wen = 0;
      i_addr = '0; d_addr = '0; d_store = '0; d_width = 3'b010;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         // compare against the model's view of this cycle
         check("r_req",   bus.mem_req,   m_busy);
         check("r_ihit",  bus.ihit,      m_ihit);
         check("r_dhit",  bus.dhit,      m_dhit);
         check("r_iload", bus.imem_load, m_iload);
         check("r_dload", bus.dmem_load, m_dload);
         if (m_busy) begin
            check("r_addr",  bus.mem_addr,  m_addr);
            check("r_we",    bus.mem_we,    m_we);
            check("r_width", bus.mem_width, m_width);
            if (m_we) check("r_wdata", bus.mem_wdata, m_wdata);
         end

         // fetch requester: holds level until ihit, sometimes lags one cycle
         if (m_ihit) begin
            if ($urandom_range(0, 1) == 1) i_drop = 1; else i_req = 0;
         end else if (i_drop) begin
            i_req = 0; i_drop = 0;
         end else if (!i_req && $urandom_range(0, 3) == 0) begin
            i_req = 1; i_addr = rand_addr();
         end
         // data requester
         if (m_dhit) begin
            if ($urandom_range(0, 1) == 1) d_drop = 1; else d_req = 0;
         end else if (d_drop) begin
            d_req = 0; d_drop = 0;
         end else if (!d_req && $urandom_range(0, 3) == 0) begin
            d_req = 1; kind = $urandom_range(0, 2);
            d_ren = (kind != 1); d_wen = (kind != 0);
            d_addr = rand_addr(); d_store = $urandom; d_width = 3'($urandom_range(0, 7));
         end
         // a granted port's inputs are noise until its hit
         i_gr = m_busy && !m_isd;
         d_gr = m_busy && m_isd;
         bus.imem_ren   = i_gr ? 1'($urandom_range(0, 1)) : i_req;
         bus.imem_addr  = i_gr ? addr_t'($urandom)       : i_addr;
         bus.dmem_ren   = d_gr ? 1'($urandom_range(0, 1)) : (d_req && d_ren);
         bus.dmem_wen   = d_gr ? 1'($urandom_range(0, 1)) : (d_req && d_wen);
         bus.dmem_addr  = d_gr ? addr_t'($urandom)       : d_addr;
         bus.dmem_store = d_gr ? word_t'($urandom)       : d_store;
         bus.dmem_width = d_gr ? 3'($urandom_range(0, 7)) : d_width;

         // memory: random wait states, stray ready while idle
         if (m_busy) begin
            if (w_left == 0) begin
               bus.mem_ready = 1'b1;
               bus.mem_rdata = ref_mem[bus.mem_addr[9:2]];
            end else begin
               bus.mem_ready = 1'b0;
               bus.mem_rdata = $urandom;
               w_left--;
            end
         end else begin
            bus.mem_ready = ($urandom_range(0, 9) == 0);
            bus.mem_rdata = $urandom;
         end

         // model: what the next cycle should look like
         nih = 0; ndh = 0;
         if (m_busy) begin
            if (bus.mem_ready) begin
               if (m_isd) begin
                  ndh = 1; cnt_d++;
                  if (m_we) ref_mem[m_addr[9:2]] = m_wdata;
                  else      m_dload = ref_mem[m_addr[9:2]];
               end else begin
                  nih = 1; cnt_i++;
                  m_iload = ref_mem[m_addr[9:2]];
               end
               m_busy = 0;
            end else begin
               cnt_w++;
            end
         end else if ((bus.dmem_ren || bus.dmem_wen) && !m_dhit) begin
            m_busy = 1; m_isd = 1; m_addr = bus.dmem_addr; m_wdata = bus.dmem_store;
            m_we = bus.dmem_wen; m_width = bus.dmem_width; w_left = $urandom_range(0, 3);
         end else if (bus.imem_ren && !m_ihit) begin
            m_busy = 1; m_isd = 0; m_addr = bus.imem_addr; m_wdata = '0;
            m_we = 0; m_width = 3'b010; w_left = $urandom_range(0, 3);
         end
         m_ihit = nih; m_dhit = ndh;
      end

      @(negedge clk);
      check("r_final_ihit", bus.ihit, m_ihit);
      check("r_final_dhit", bus.dhit, m_dhit);
`ifdef MEMORY_ARBITER_PERF_EN
      check("r_perf_ifetch",  pf_i, cnt_i);
      check("r_perf_daccess", pf_d, cnt_d);
      check("r_perf_wait",    pf_w, cnt_w);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
